multiply_long: RTL and testbench

- Sequential 32x32 matrix multiplier for 8-bit unsigned elements: C = A x B, each result truncated to 8 bits.
- Sits in the accelerator subsystem. Operand matrices arrive as 256-word x 32-bit arrays; the result is returned in the same format.
- Computes one C element per clock and pulses done when all 1024 elements are written.

---
 rtl/multiply_long.sv | 103 ++++++++++
 tb/tb_multiply_long.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiply_long.sv
// Sequential 32x32 matrix multiplier over 8-bit unsigned elements.
// One C element per clock from a combinational 32-term dot product, results mod 256.
module multiply_long (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0][7:0] mat_A [256],
  input  logic [3:0][7:0] mat_B [256],
  output logic [3:0][7:0] mat_C [256],
  output logic            done
);

  localparam int unsigned DIM      = 32;
  localparam int unsigned WORDS    = 256;
  localparam int unsigned CNT_W    = 10;
  localparam int unsigned PROD_W   = 16;
  localparam int unsigned ACC_W    = 21;
  localparam int unsigned LAST_IDX = 1023;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               wr_en_c;
  logic [3:0][7:0]    mat_c_q [WORDS];

  logic [4:0]         row_c, col_c;
  logic [PROD_W-1:0]  prod_c [DIM];
  logic [ACC_W-1:0]   acc_c;

  assign row_c = cnt_q[9:5];
  assign col_c = cnt_q[4:0];

  // A[row][k] sits in word row*8 + k/4; B[k][col] in word k*8 + col/4.
  always_comb begin
    for (int k = 0; k < DIM; k++) begin
      prod_c[k] = PROD_W'(mat_A[{row_c, 3'(k >> 2)}][2'(k)])
                * PROD_W'(mat_B[{5'(k), col_c[4:2]}][col_c[1:0]]);
    end
  end

  always_comb begin
    acc_c = '0;
    for (int k = 0; k < DIM; k++) begin
      acc_c = acc_c + ACC_W'(prod_c[k]);
    end
  end

  // Next-state, counter and done pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_en_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        wr_en_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST_IDX)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WORDS; w++) begin
        mat_c_q[w] <= '0;
      end
    end else if (wr_en_c) begin
      mat_c_q[cnt_q[9:2]][cnt_q[1:0]] <= acc_c[7:0];
    end
  end

  assign mat_C = mat_c_q;
  assign done  = done_q;

endmodule

// File: tb/tb_multiply_long.sv
// Directed bench for multiply_long: reset, idle, arithmetic, wrap and handshake timing.
module tb_multiply_long;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [3:0][7:0] mat_A [256];
  logic [3:0][7:0] mat_B [256];
  logic [3:0][7:0] mat_C [256];
  logic            done;

  int checks;
  int errors;

  multiply_long dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mat_A (mat_A),
    .mat_B (mat_B),
    .mat_C (mat_C),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_uniform(input logic [7:0] a, input logic [7:0] b);
    for (int w = 0; w < 256; w++) begin
      for (int l = 0; l < 4; l++) begin
        mat_A[w][l] = a;
        mat_B[w][l] = b;
      end
    end
  endtask

  function automatic int count_bad(input logic [7:0] exp);
    int n;
    n = 0;
    for (int w = 0; w < 256; w++)
      for (int l = 0; l < 4; l++)
        if (mat_C[w][l] !== exp) n++;
    return n;
  endfunction

  // Launches a run and returns edges from the start edge until done is seen (3000 = timeout).
  task automatic launch_and_wait(output int n);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    int bad;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %0b want 0", done);
    end
    bad = count_bad(8'd0);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_matc nonzero bytes %0d want 0", bad);
    end
  endtask

  task automatic test_no_start;
    int seen;
    int bad;
    set_uniform(8'd2, 8'd3);
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL nostart_done pulses %0d want 0", seen);
    end
    bad = count_bad(8'd0);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL nostart_matc nonzero bytes %0d want 0", bad);
    end
  endtask

  task automatic test_uniform;
    int n;
    int bad;
    set_uniform(8'd2, 8'd3);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (mat_C[0][0] !== 8'd0) begin
      errors++;
      $display("FAIL elem0_edge0 got %0d want 0", mat_C[0][0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (mat_C[0][0] !== 8'd192 || mat_C[0][1] !== 8'd0) begin
      errors++;
      $display("FAIL elem0_edge1 got c0=%0d c1=%0d want 192 0", mat_C[0][0], mat_C[0][1]);
    end
    n = 1;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL uniform_done_edge got %0d want 1024", n);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL uniform_done_width got %0b want 0", done);
    end
    checks++;
    if (mat_C[0] !== 32'hC0C0C0C0) begin
      errors++;
      $display("FAIL uniform_word0 got %08h want c0c0c0c0", mat_C[0]);
    end
    bad = count_bad(8'd192);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL uniform_all bad bytes %0d want 0", bad);
    end
  endtask

  task automatic test_identity;
    int n;
    int bad;
    for (int i = 0; i < 1024; i++) begin
      mat_A[i / 4][i % 4] = ((i / 32) == (i % 32)) ? 8'd1 : 8'd0;
      mat_B[i / 4][i % 4] = 8'(i);
    end
    launch_and_wait(n);
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL identity_done_edge got %0d want 1024", n);
    end
    checks++;
    if (mat_C[1] !== 32'h07060504) begin
      errors++;
      $display("FAIL identity_word1 got %08h want 07060504", mat_C[1]);
    end
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (mat_C[i / 4][i % 4] !== 8'(i)) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL identity_all bad bytes %0d want 0", bad);
    end
  endtask

  task automatic test_start_ignored;
    int n;
    int extra;
    int bad;
    set_uniform(8'd1, 8'd1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == 300);
    end
    start = 1'b0;
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL ignored_done_edge got %0d want 1024", n);
    end
    extra = 0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignored_extra_done got %0d want 0", extra);
    end
    bad = count_bad(8'd32);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ignored_result bad bytes %0d want 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int bad;
    set_uniform(8'd2, 8'd3);
    launch_and_wait(n);
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL b2b_first_done got %0d want 1024", n);
    end
    // start raised inside the done cycle; the next edge is edge 0 of the new run.
    set_uniform(8'd16, 8'd16);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL b2b_second_done got %0d want 1024", n);
    end
    bad = count_bad(8'd0);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL wrap16_result bad bytes %0d want 0", bad);
    end
    set_uniform(8'd255, 8'd1);
    launch_and_wait(n);
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL wrap255_done got %0d want 1024", n);
    end
    bad = count_bad(8'd224);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL wrap255_result bad bytes %0d want 0", bad);
    end
  endtask

  task automatic test_mid_reset;
    int n;
    int bad;
    int seen;
    set_uniform(8'd2, 8'd3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    #1;
    bad = count_bad(8'd0);
    checks++;
    if (bad !== 0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear nonzero bytes %0d done %0b want 0 0", bad, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    bad = count_bad(8'd0);
    checks++;
    if (seen !== 0 || bad !== 0) begin
      errors++;
      $display("FAIL midreset_idle done pulses %0d nonzero bytes %0d want 0 0", seen, bad);
    end
    launch_and_wait(n);
    checks++;
    if (n !== 1024) begin
      errors++;
      $display("FAIL midreset_restart_done got %0d want 1024", n);
    end
    bad = count_bad(8'd192);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midreset_restart_result bad bytes %0d want 0", bad);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    set_uniform(8'd0, 8'd0);
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_no_start;
    test_uniform;
    test_identity;
    test_start_ignored;
    test_back_to_back;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
